// File: rtl/jellyvl_etherneco_tx_framer.sv
// rtl/jellyvl_etherneco_tx_framer.sv - store-and-forward Ethernet TX framer
// Buffers whole frames, then emits preamble, SFD, payload and an inter-frame gap.
`timescale 1ns/1ps
module jellyvl_etherneco_tx_framer #(
  parameter int PTR_WIDTH    = 11,
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES   = 12
) (
  input  logic                 reset,
  input  logic                 clk,
  input  logic                 s_first,
  input  logic                 s_last,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 m_first,
  output logic                 m_last,
  output logic [7:0]           m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 drop,
  output logic [PTR_WIDTH:0]   frame_count
);

  typedef logic [PTR_WIDTH:0] ptr_t;
  localparam ptr_t DEPTH = ptr_t'(1) << PTR_WIDTH;

  typedef enum logic [2:0] {IDLE, PRE, SFD, PAY, IFG} state_t;

  logic [8:0] mem [0:(1<<PTR_WIDTH)-1];

  ptr_t   wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, rd_ptr_d;
  ptr_t   fc_q, fc_d;
  logic   open_q, open_d, bad_q, bad_d, drop_q, drop_d;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  logic       wr_en;
  ptr_t       wr_addr;
  ptr_t       base;
  logic       frame_bad;
  logic       commit;
  logic       sent_last;
  logic [8:0] rd_entry;
  logic       m_valid_c, m_first_c, m_last_c;
  logic [7:0] m_data_c;

  // Write side: a new s_first always restarts at the commit pointer, which
  // implicitly discards any partial frame still open.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    open_d    = open_q;
    bad_d     = bad_q;
    drop_d    = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = wr_ptr_q;
    commit    = 1'b0;
    base      = s_first ? cmt_ptr_q : wr_ptr_q;
    frame_bad = s_first ? 1'b0 : bad_q;
    if (s_valid && (s_first || open_q)) begin
      if (s_first && open_q) begin
        drop_d = 1'b1;
      end
      if (!frame_bad && (ptr_t'(base - rd_ptr_q) == DEPTH)) begin
        frame_bad = 1'b1;
      end
      if (!frame_bad) begin
        wr_en   = 1'b1;
        wr_addr = base;
        base    = base + ptr_t'(1);
      end
      if (s_last) begin
        open_d = 1'b0;
        bad_d  = 1'b0;
        if (frame_bad) begin
          wr_ptr_d = cmt_ptr_q;
          drop_d   = 1'b1;
        end else begin
          commit    = 1'b1;
          cmt_ptr_d = base;
          wr_ptr_d  = base;
        end
      end else begin
        open_d   = 1'b1;
        bad_d    = frame_bad;
        wr_ptr_d = base;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr[PTR_WIDTH-1:0]] <= {s_last, s_data};
    end
  end

  assign rd_entry = mem[rd_ptr_q[PTR_WIDTH-1:0]];

  // Read side. The IFG exit goes straight to PRE when a frame is waiting so
  // that back-to-back frames are separated by exactly IFG_CYCLES idle cycles.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_ptr_d  = rd_ptr_q;
    sent_last = 1'b0;
    m_valid_c = 1'b0;
    m_first_c = 1'b0;
    m_last_c  = 1'b0;
    m_data_c  = 8'h00;
    case (state_q)
      IDLE: begin
        if (fc_q != '0) begin
          state_d = PRE;
          cnt_d   = '0;
        end
      end
      PRE: begin
        m_valid_c = 1'b1;
        m_data_c  = 8'h55;
        m_first_c = (cnt_q == '0);
        if (m_ready) begin
          if (cnt_q == 16'(PREAMBLE_LEN - 1)) begin
            state_d = SFD;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      SFD: begin
        m_valid_c = 1'b1;
        m_data_c  = 8'hD5;
        if (m_ready) begin
          state_d = PAY;
        end
      end
      PAY: begin
        m_valid_c = (rd_ptr_q != cmt_ptr_q);
        if (m_valid_c) begin
          m_data_c = rd_entry[7:0];
          m_last_c = rd_entry[8];
        end
        if (m_valid_c && m_ready) begin
          rd_ptr_d = rd_ptr_q + ptr_t'(1);
          if (rd_entry[8]) begin
            sent_last = 1'b1;
            state_d   = IFG;
            cnt_d     = '0;
          end
        end
      end
      IFG: begin
        if (cnt_q == 16'(IFG_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = (fc_q != '0) ? PRE : IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fc_d = fc_q + ptr_t'(commit) - ptr_t'(sent_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      rd_ptr_q  <= '0;
      fc_q      <= '0;
      open_q    <= 1'b0;
      bad_q     <= 1'b0;
      drop_q    <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fc_q      <= fc_d;
      open_q    <= open_d;
      bad_q     <= bad_d;
      drop_q    <= drop_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

  assign m_valid     = m_valid_c & ~reset;
  assign m_first     = m_first_c & ~reset;
  assign m_last      = m_last_c  & ~reset;
  assign m_data      = reset ? 8'h00 : m_data_c;
  assign drop        = drop_q & ~reset;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_jellyvl_etherneco_tx_framer.sv
// tb/tb_jellyvl_etherneco_tx_framer.sv - self-checking bench for the TX framer
// Expected byte streams come from a frame-level model of preamble/SFD/payload.
`timescale 1ns/1ps
module tb_jellyvl_etherneco_tx_framer;
  localparam int PTR_WIDTH = 11;
  localparam int PRE_LEN   = 7;
  localparam int IFG_LEN   = 12;
  localparam int DEPTH     = 1 << PTR_WIDTH;

  typedef struct packed {logic first; logic last; logic [7:0] data;} ob_t;
  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic reset, s_first, s_last, s_valid, m_ready;
  logic [7:0] s_data;
  logic m_first, m_last, m_valid, drop;
  logic [7:0] m_data;
  logic [PTR_WIDTH:0] frame_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_edge = 0;
  int drop_cnt = 0;
  int stab_err = 0;
  int valid_cnt = 0;
  int fc_max = 0;
  int ready_mode = 0;
  ob_t got_q[$];
  int  got_cyc[$];
  ob_t exp_q[$];
  logic hold_v = 1'b0;
  ob_t  hold_b;

  jellyvl_etherneco_tx_framer #(
    .PTR_WIDTH(PTR_WIDTH), .PREAMBLE_LEN(PRE_LEN), .IFG_CYCLES(IFG_LEN)
  ) dut (
    .reset(reset), .clk(clk),
    .s_first(s_first), .s_last(s_last), .s_data(s_data), .s_valid(s_valid),
    .m_first(m_first), .m_last(m_last), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .drop(drop), .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    if (ready_mode == 1) m_ready = ~m_ready;
    else if (ready_mode == 2) m_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (hold_v && !(m_valid && ({m_first, m_last, m_data} === hold_b))) stab_err++;
      if (m_valid) valid_cnt++;
      if (m_valid && m_ready) begin
        got_q.push_back({m_first, m_last, m_data});
        got_cyc.push_back(cyc);
      end
      if (drop) drop_cnt++;
      if (int'(frame_count) > fc_max) fc_max = int'(frame_count);
      hold_v = m_valid && !m_ready;
      hold_b = {m_first, m_last, m_data};
    end else begin
      hold_v = 1'b0;
    end
  end

  function automatic ob_t mk(input logic f, input logic l, input logic [7:0] d);
    mk = {f, l, d};
  endfunction

  function automatic int first_diff();
    if (got_q.size() != exp_q.size()) return -2;
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic add_exp(input byte_q_t p);
    for (int i = 0; i < PRE_LEN; i++) exp_q.push_back(mk(i == 0, 1'b0, 8'h55));
    exp_q.push_back(mk(1'b0, 1'b0, 8'hD5));
    foreach (p[i]) exp_q.push_back(mk(1'b0, i == p.size() - 1, p[i]));
  endtask

  task automatic clear_obs();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic drive(input logic f, input logic l, input logic v, input logic [7:0] d);
    s_first = f; s_last = l; s_valid = v; s_data = d;
    @(posedge clk);
    #1;
    if (v && l) last_edge = cyc;
  endtask

  task automatic send_frame(input byte_q_t p);
    foreach (p[i]) drive(i == 0, i == p.size() - 1, 1'b1, p[i]);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    if (p.size() <= DEPTH) add_exp(p);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((got_q.size() < exp_q.size() || frame_count != 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_done: got %0d bytes, required %0d before timeout", got_q.size(), exp_q.size());
    end
    repeat (IFG_LEN + 2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; s_first = 0; s_last = 0; s_valid = 0; s_data = 0; m_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({m_valid, m_first, m_last, drop, m_data} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got v%b f%b l%b d%b data %h, required all 0", m_valid, m_first, m_last, drop, m_data);
    end
    checks++;
    if (frame_count !== '0) begin
      errors++;
      $display("FAIL reset_frame_count: got %0d, required 0", frame_count);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    byte_q_t p = '{8'h11, 8'h12, 8'h13, 8'h14};
    int d;
    clear_obs();
    ready_mode = 0; m_ready = 1'b1;
    send_frame(p);
    wait_done(200);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL single_stream: diff idx %0d, got %0d bytes, required %0d", d, got_q.size(), exp_q.size());
    end
    if (got_cyc.size() == 12) begin
      checks++;
      if (got_cyc[0] != last_edge + 1) begin
        errors++;
        $display("FAIL single_latency: first valid at edge %0d, required %0d", got_cyc[0], last_edge + 1);
      end
      checks++;
      if (got_cyc[11] - got_cyc[0] != 11) begin
        errors++;
        $display("FAIL single_contiguous: span %0d, required 11", got_cyc[11] - got_cyc[0]);
      end
    end
  endtask

  task automatic test_stall();
    byte_q_t p = '{8'h11, 8'h12, 8'h13, 8'h14};
    int d, s0;
    clear_obs();
    s0 = stab_err;
    m_ready = 1'b1; ready_mode = 1;
    send_frame(p);
    wait_done(400);
    ready_mode = 0; m_ready = 1'b1;
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL stall_stream: diff idx %0d, got %0d bytes, required %0d", d, got_q.size(), exp_q.size());
    end
    checks++;
    if (stab_err != s0) begin
      errors++;
      $display("FAIL stall_stable: %0d unstable stall cycles, required 0", stab_err - s0);
    end
  endtask

  task automatic test_oversize();
    byte_q_t p;
    int d0, v0;
    clear_obs();
    repeat (DEPTH + 1) p.push_back(8'($urandom));
    d0 = drop_cnt; v0 = valid_cnt; fc_max = 0;
    send_frame(p);
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (drop_cnt - d0 != 1) begin
      errors++;
      $display("FAIL oversize_drop: got %0d pulses, required 1", drop_cnt - d0);
    end
    checks++;
    if (fc_max != 0 || valid_cnt != v0) begin
      errors++;
      $display("FAIL oversize_quiet: frame_count max %0d, valid cycles %0d, required 0 and 0", fc_max, valid_cnt - v0);
    end
  endtask

  task automatic test_abort();
    byte_q_t p = '{8'hA1, 8'hA2};
    int d, d0;
    clear_obs();
    d0 = drop_cnt;
    drive(1'b0, 1'b0, 1'b1, 8'hEE);
    drive(1'b1, 1'b0, 1'b1, 8'h01);
    drive(1'b0, 1'b0, 1'b1, 8'h02);
    drive(1'b0, 1'b0, 1'b1, 8'h03);
    send_frame(p);
    wait_done(200);
    checks++;
    if (drop_cnt - d0 != 1) begin
      errors++;
      $display("FAIL abort_drop: got %0d pulses, required 1", drop_cnt - d0);
    end
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL abort_stream: diff idx %0d, got %0d bytes, required %0d", d, got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int d, nlast;
    byte_q_t p;
    clear_obs();
    ready_mode = 0; m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      p.delete();
      p.push_back(8'h30 + 8'(k));
      drive(1'b1, 1'b1, 1'b1, p[0]);
      add_exp(p);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (frame_count !== 12'd3) begin
      errors++;
      $display("FAIL b2b_count: got %0d, required 3", frame_count);
    end
    m_ready = 1'b1;
    wait_done(300);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL b2b_stream: diff idx %0d, got %0d bytes, required %0d", d, got_q.size(), exp_q.size());
    end
    nlast = 0;
    for (int i = 0; i + 1 < got_q.size(); i++) begin
      if (got_q[i].last) begin
        nlast++;
        checks++;
        if (got_cyc[i + 1] - got_cyc[i] - 1 != IFG_LEN) begin
          errors++;
          $display("FAIL b2b_gap: gap %0d idle cycles after frame %0d, required %0d", got_cyc[i + 1] - got_cyc[i] - 1, nlast, IFG_LEN);
        end
      end
    end
  endtask

  task automatic test_random();
    byte_q_t p;
    int d, s0;
    clear_obs();
    s0 = stab_err;
    ready_mode = 2;
    for (int k = 0; k < 6; k++) begin
      p.delete();
      repeat ($urandom_range(1, 24)) p.push_back(8'($urandom));
      send_frame(p);
      repeat ($urandom_range(0, 3)) drive(1'b0, 1'b0, 1'b0, 8'h00);
    end
    wait_done(6000);
    ready_mode = 0; m_ready = 1'b1;
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL random_stream: diff idx %0d, got %0d bytes, required %0d", d, got_q.size(), exp_q.size());
    end
    checks++;
    if (stab_err != s0) begin
      errors++;
      $display("FAIL random_stable: %0d unstable stall cycles, required 0", stab_err - s0);
    end
  endtask

  task automatic test_reset_mid();
    byte_q_t p = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};
    byte_q_t q = '{8'h5A};
    int n, d, d0;
    clear_obs();
    ready_mode = 0; m_ready = 1'b1;
    send_frame(p);
    n = 0;
    while (got_q.size() < PRE_LEN + 3 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    d0 = drop_cnt;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || frame_count !== '0) begin
      errors++;
      $display("FAIL reset_mid_state: got m_valid %b frame_count %0d, required 0 and 0", m_valid, frame_count);
    end
    reset = 1'b0;
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    send_frame(q);
    wait_done(200);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL reset_mid_stream: diff idx %0d, got %0d bytes, required %0d", d, got_q.size(), exp_q.size());
    end
    checks++;
    if (drop_cnt != d0) begin
      errors++;
      $display("FAIL reset_mid_drop: got %0d pulses, required 0", drop_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_oversize();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
